// File: rtl/serial_parity_checker_if.sv
// Handshake bundle for the serial parity checker: bit stream in, parity result out.
// The master drives stimulus and consumes results; the slave is the checker.
interface serial_parity_checker_if #(
  parameter int CNT_W = 3
);
  logic             start;
  logic             bit_in;
  logic             bit_vld;
  logic             bit_rdy;
  logic             par_out;
  logic             err;
  logic             done_vld;
  logic             done_rdy;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output start, bit_in, bit_vld, done_rdy,
    input  bit_rdy, par_out, err, done_vld, busy, bit_cnt
  );

  modport slave (
    input  start, bit_in, bit_vld, done_rdy,
    output bit_rdy, par_out, err, done_vld, busy, bit_cnt
  );
endinterface

// File: rtl/serial_parity_checker.sv
// Folds a FRAME_LEN-bit serial frame through a running XOR, then checks one
// trailing parity bit and presents (par_out, err) on a valid/ready result port.
module serial_parity_checker #(
  parameter int FRAME_LEN  = 8,
  parameter bit PARITY_ODD = 1'b0,
  parameter int CNT_W      = $clog2(FRAME_LEN)
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_parity_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t           state_r;
  logic             acc_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             par_out_r;
  logic             err_r;
  logic             done_vld_r;
  logic             bit_rdy_r;
  logic             busy_r;
  logic             accept_s;

  function automatic logic xor_fold(input logic acc, input logic din);
    return acc ^ din;
  endfunction

  assign accept_s     = bus.bit_vld & bit_rdy_r;
  assign bus.bit_rdy  = bit_rdy_r;
  assign bus.par_out  = par_out_r;
  assign bus.err      = err_r;
  assign bus.done_vld = done_vld_r;
  assign bus.busy     = busy_r;
  assign bus.bit_cnt  = bit_cnt_r;

  // Frame FSM; handshake outputs are registered alongside the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      acc_r      <= 1'b0;
      bit_cnt_r  <= '0;
      par_out_r  <= 1'b0;
      err_r      <= 1'b0;
      done_vld_r <= 1'b0;
      bit_rdy_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r   <= DATA;
            acc_r     <= 1'b0;
            bit_cnt_r <= '0;
            bit_rdy_r <= 1'b1;
            busy_r    <= 1'b1;
          end else begin
            bit_rdy_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        DATA: begin
          if (accept_s) begin
            acc_r <= xor_fold(acc_r, bus.bit_in);
            // The last data bit leaves the count at FRAME_LEN-1 so it never wraps.
            if (bit_cnt_r == LAST_CNT) begin
              state_r <= PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= DATA;
          end
        end
        PARITY: begin
          if (accept_s) begin
            par_out_r  <= xor_fold(acc_r, PARITY_ODD);
            err_r      <= xor_fold(xor_fold(acc_r, PARITY_ODD), bus.bit_in);
            state_r    <= DONE;
            bit_rdy_r  <= 1'b0;
            done_vld_r <= 1'b1;
          end else begin
            state_r <= PARITY;
          end
        end
        DONE: begin
          if (bus.done_rdy) begin
            state_r    <= IDLE;
            done_vld_r <= 1'b0;
            bit_cnt_r  <= '0;
            busy_r     <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          bit_cnt_r  <= '0;
          done_vld_r <= 1'b0;
          bit_rdy_r  <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench driving an even- and an odd-parity checker with shared stimulus;
// expected results are queued at parity-bit time and popped when done_vld rises.
module tb_serial_parity_checker;

  logic clk;
  logic rst_n;
  logic start;
  logic bit_in;
  logic bit_vld;
  logic done_rdy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic pe;
    logic ee;
    logic po;
    logic eo;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  logic prev_dv;

  serial_parity_checker_if #(.CNT_W(3)) if_e ();
  serial_parity_checker_if #(.CNT_W(3)) if_o ();

  assign if_e.start    = start;
  assign if_e.bit_in   = bit_in;
  assign if_e.bit_vld  = bit_vld;
  assign if_e.done_rdy = done_rdy;
  assign if_o.start    = start;
  assign if_o.bit_in   = bit_in;
  assign if_o.bit_vld  = bit_vld;
  assign if_o.done_rdy = done_rdy;

  serial_parity_checker #(.FRAME_LEN(8), .PARITY_ODD(1'b0)) dut_even (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_e.slave)
  );

  serial_parity_checker #(.FRAME_LEN(8), .PARITY_ODD(1'b1)) dut_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_o.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy_e"},  8'(if_e.bit_rdy),  8'd0);
    chk({tag, "_dv_e"},   8'(if_e.done_vld), 8'd0);
    chk({tag, "_busy_e"}, 8'(if_e.busy),     8'd0);
    chk({tag, "_cnt_e"},  8'(if_e.bit_cnt),  8'd0);
    chk({tag, "_busy_o"}, 8'(if_o.busy),     8'd0);
    chk({tag, "_cnt_o"},  8'(if_o.bit_cnt),  8'd0);
  endtask

  // Starts a frame and sends data[0] first; optional stalls and a stray start at bit_cnt=4.
  task automatic run_data(input logic [7:0] data, input int nbits, input bit stalls, input bit abuse);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_busy", 8'(if_e.busy),    8'd1);
    chk("start_rdy",  8'(if_o.bit_rdy), 8'd1);
    chk("start_cnt",  8'(if_e.bit_cnt), 8'd0);
    for (int i = 0; i < nbits; i++) begin
      bit_in  = data[i];
      bit_vld = 1'b1;
      start   = (abuse && i == 4) ? 1'b1 : 1'b0;
      cyc();
      bit_vld = 1'b0;
      start   = 1'b0;
      chk("cnt_e", 8'(if_e.bit_cnt), (i == 7) ? 8'd7 : 8'(i + 1));
      chk("cnt_o", 8'(if_o.bit_cnt), (i == 7) ? 8'd7 : 8'(i + 1));
      chk("no_early_done", 8'(if_e.done_vld), 8'd0);
      if (stalls && (i == 2 || i == 5)) begin
        for (int s = 0; s < 2; s++) begin
          cyc();
          chk("stall_cnt",  8'(if_e.bit_cnt), 8'(i + 1));
          chk("stall_busy", 8'(if_o.busy),    8'd1);
        end
      end
    end
  endtask

  task automatic send_parity(input logic [7:0] data, input logic pbit);
    logic x;
    x = ^data;
    last_exp = '{pe: x, ee: x ^ pbit, po: ~x, eo: ~x ^ pbit};
    sb.push_back(last_exp);
    bit_in  = pbit;
    bit_vld = 1'b1;
    cyc();
    bit_vld = 1'b0;
    chk("dv_at_edge_e", 8'(if_e.done_vld), 8'd1);
    chk("dv_at_edge_o", 8'(if_o.done_vld), 8'd1);
    chk("rdy_in_done",  8'(if_e.bit_rdy),  8'd0);
  endtask

  task automatic release_result(input int hold);
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk("hold_dv",  8'(if_e.done_vld), 8'd1);
      chk("hold_par", 8'(if_e.par_out),  8'(last_exp.pe));
      chk("hold_err", 8'(if_e.err),      8'(last_exp.ee));
      chk("hold_err_o", 8'(if_o.err),    8'(last_exp.eo));
    end
    done_rdy = 1'b1;
    cyc();
    done_rdy = 1'b0;
    chk_idle("after_done");
    chk("par_kept", 8'(if_o.par_out), 8'(last_exp.po));
  endtask

  // Scoreboard consumer: one expected entry per rising done_vld.
  always @(negedge clk) begin
    if (rst_n && if_e.done_vld && !prev_dv) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 8'd1, 8'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_par_e", 8'(if_e.par_out),  8'(e.pe));
        chk("sb_err_e", 8'(if_e.err),      8'(e.ee));
        chk("sb_par_o", 8'(if_o.par_out),  8'(e.po));
        chk("sb_err_o", 8'(if_o.err),      8'(e.eo));
        chk("sb_dv_o",  8'(if_o.done_vld), 8'd1);
      end
    end
    prev_dv <= if_e.done_vld;
  end

  initial begin
    prev_dv  = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    bit_in   = 1'b0;
    bit_vld  = 1'b0;
    done_rdy = 1'b0;
    #1;
    chk_idle("reset");
    repeat (3) cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_idle("idle");
    end

    // Bits offered in IDLE must not be consumed.
    bit_vld = 1'b1;
    bit_in  = 1'b1;
    cyc();
    cyc();
    bit_vld = 1'b0;
    chk_idle("idle_bits");

    // Frame A: XOR=0, correct even parity.
    run_data(8'b0100_1101, 8, 1'b0, 1'b0);
    send_parity(8'b0100_1101, 1'b0);
    release_result(0);

    // Frame B: same data, wrong parity, result held 5 cycles.
    run_data(8'b0100_1101, 8, 1'b0, 1'b0);
    send_parity(8'b0100_1101, 1'b1);
    release_result(5);

    // Frame C: XOR=1 with stalls and a stray start mid-frame.
    run_data(8'b0000_0111, 8, 1'b1, 1'b1);
    send_parity(8'b0000_0111, 1'b0);
    chk("c_par_o", 8'(if_o.par_out), 8'd0);
    chk("c_err_o", 8'(if_o.err),     8'd0);
    start    = 1'b1;
    done_rdy = 1'b1;
    cyc();
    start    = 1'b0;
    done_rdy = 1'b0;
    chk_idle("start_with_rdy");
    cyc();
    chk_idle("start_ignored");

    // Abort mid-frame with an asynchronous reset at bit_cnt=5.
    run_data(8'b0001_0110, 5, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("rst_par_e", 8'(if_e.par_out), 8'd0);
    chk("rst_err_e", 8'(if_e.err),     8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk_idle("post_rst");

    // Fresh frame of eight ones, even parity bit 0.
    run_data(8'hFF, 8, 1'b0, 1'b0);
    send_parity(8'hFF, 1'b0);
    release_result(1);

    repeat (2) cyc();
    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
